// File: rtl/connect4_pkg.sv
// connect4_pkg: shared types and constants for the connect-four board logic.
// Holds the status encodings, the win-detector state enum, board geometry
// and the table that maps each candidate line to its four cell indices.
package connect4_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int BOARD_W = ROWS * COLS;

    typedef enum logic [1:0] {
        ST_PLAYING = 2'b00,
        ST_P1_WIN  = 2'b01,
        ST_P2_WIN  = 2'b10,
        ST_DRAW    = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Cell index = row*4 + col, row 0 at the bottom.
    // Lines 0-3 are rows, 4-7 columns, 8 the diagonal, 9 the anti-diagonal.
    localparam logic [3:0] LINE_CELLS [10][4] = '{
        '{4'd0,  4'd1,  4'd2,  4'd3 },
        '{4'd4,  4'd5,  4'd6,  4'd7 },
        '{4'd8,  4'd9,  4'd10, 4'd11},
        '{4'd12, 4'd13, 4'd14, 4'd15},
        '{4'd0,  4'd4,  4'd8,  4'd12},
        '{4'd1,  4'd5,  4'd9,  4'd13},
        '{4'd2,  4'd6,  4'd10, 4'd14},
        '{4'd3,  4'd7,  4'd11, 4'd15},
        '{4'd0,  4'd5,  4'd10, 4'd15},
        '{4'd3,  4'd6,  4'd9,  4'd12}
    };

endpackage

// File: rtl/win_detector_if.sv
// win_detector_if: start strobe, board maps and result signals of the win
// detector. The producer of the board (and consumer of the result) uses the
// master modport; the detector itself uses the slave modport.
interface win_detector_if;
    import connect4_pkg::*;

    logic               start;
    logic [BOARD_W-1:0] in_gameboard;
    logic [BOARD_W-1:0] in_players_cells;
    logic [1:0]         out_game_status;
    logic               busy;
    logic               done;
    logic [3:0]         win_line;

    modport master (
        output start, in_gameboard, in_players_cells,
        input  out_game_status, busy, done, win_line
    );

    modport slave (
        input  start, in_gameboard, in_players_cells,
        output out_game_status, busy, done, win_line
    );

endinterface

// File: rtl/win_detector_line_eval.sv
// line_eval: decides whether one four-cell line is a win. A line wins when
// all four cells are occupied and all four share one owner.
module line_eval (
    input  logic [3:0] occ,
    input  logic [3:0] own,
    output logic       win,
    output logic       owner
);

    assign win   = (&occ) && ((&own) || (~|own));
    assign owner = own[0];

endmodule

// File: rtl/win_detector.sv
// win_detector: snapshots the board on start and checks one candidate line
// per clock, in ascending order, reporting the first winning line, a draw on
// a full board, or "still playing". Terminal results hold until reset.
// Build option: define WIN_DIAG_EN to include the two diagonals (10 lines);
// otherwise only rows and columns are scanned (8 lines).
module win_detector
    import connect4_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    win_detector_if.slave  bus
);

`ifdef WIN_DIAG_EN
    localparam int NUM_LINES = 10;
`else
    localparam int NUM_LINES = 8;
`endif
    localparam logic [3:0] LAST_IDX = 4'(NUM_LINES - 1);

    state_t             state, state_nx;
    logic [3:0]         idx, idx_nx;
    logic [BOARD_W-1:0] snap_board, snap_board_nx;
    logic [BOARD_W-1:0] snap_cells, snap_cells_nx;
    status_t            status, status_nx;
    logic [3:0]         win_line, win_line_nx;

    logic [3:0] line_occ;
    logic [3:0] line_own;
    logic       line_win;
    logic       line_owner;

    // Pick the four cells of the line under the counter from the snapshot.
    assign line_occ = {snap_board[LINE_CELLS[idx][3]], snap_board[LINE_CELLS[idx][2]],
                       snap_board[LINE_CELLS[idx][1]], snap_board[LINE_CELLS[idx][0]]};
    assign line_own = {snap_cells[LINE_CELLS[idx][3]], snap_cells[LINE_CELLS[idx][2]],
                       snap_cells[LINE_CELLS[idx][1]], snap_cells[LINE_CELLS[idx][0]]};

    line_eval u_line_eval (
        .occ   (line_occ),
        .own   (line_own),
        .win   (line_win),
        .owner (line_owner)
    );

    // Next-state and datapath decisions for the IDLE/SCAN/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nx      = state;
        idx_nx        = idx;
        snap_board_nx = snap_board;
        snap_cells_nx = snap_cells;
        status_nx     = status;
        win_line_nx   = win_line;
        unique case (state)
            S_IDLE: begin
                if (bus.start && status == ST_PLAYING) begin
                    snap_board_nx = bus.in_gameboard;
                    snap_cells_nx = bus.in_players_cells;
                    idx_nx        = 4'd0;
                    state_nx      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (line_win) begin
                    status_nx   = line_owner ? ST_P2_WIN : ST_P1_WIN;
                    win_line_nx = idx;
                    state_nx    = S_DONE;
                end else if (idx == LAST_IDX) begin
                    status_nx   = (&snap_board) ? ST_DRAW : ST_PLAYING;
                    win_line_nx = 4'd0;
                    state_nx    = S_DONE;
                end else begin
                    idx_nx = idx + 4'd1;
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the snapshot registers are plain flops, so clearing them on reset is cheap and keeps state deterministic.
            state      <= S_IDLE;
            idx        <= 4'd0;
            snap_board <= '0;
            snap_cells <= '0;
            status     <= ST_PLAYING;
            win_line   <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state      <= state_nx;
            idx        <= idx_nx;
            snap_board <= snap_board_nx;
            snap_cells <= snap_cells_nx;
            status     <= status_nx;
            win_line   <= win_line_nx;
        end
    end

    assign bus.out_game_status = status;
    assign bus.win_line        = win_line;
    assign bus.busy            = (state == S_SCAN);
    assign bus.done            = (state == S_DONE);

endmodule

// File: tb/tb_win_detector.sv
// tb_win_detector: table-driven checks of the win detector plus hand-written
// sequences for ignored starts, mid-scan reset and input changes during a
// scan. Expected results go to a queue at launch and are compared when done
// pulses.
module tb_win_detector;
    import connect4_pkg::*;

`ifdef WIN_DIAG_EN
    localparam int  LINES = 10;
    localparam bit  DIAG  = 1'b1;
`else
    localparam int  LINES = 8;
    localparam bit  DIAG  = 1'b0;
`endif
    localparam int FULL_LAT = LINES + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    win_detector_if bus ();

    win_detector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] status;
        logic [3:0] line;
        int         due;
    } exp_t;

    typedef struct {
        logic [15:0] board;
        logic [15:0] cells;
        logic [1:0]  status;
        logic [3:0]  line;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.due);
                check("status", {30'd0, bus.out_game_status}, {30'd0, e.status});
                check("win_line", {28'd0, bus.win_line}, {28'd0, e.line});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        bus.in_gameboard = '0;
        bus.in_players_cells = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one start pulse and queue the expected result; returns the cycle
    // count at the first negedge after the sampling edge.
    task automatic launch(input logic [15:0] board, input logic [15:0] cells,
                          input logic [1:0] st, input logic [3:0] line,
                          input int lat, output int s);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_gameboard = board;
        bus.in_players_cells = cells;
        sb.push_back('{st, line, cyc + lat});
        @(negedge clk);
        bus.start = 1'b0;
        s = cyc;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        check("status_held_in_scan", {30'd0, bus.out_game_status}, 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int dc;

        // {board, cells, status, win_line, latency from start edge to done}
        vecs.push_back('{16'h000F, 16'h0000, 2'b01, 4'd0, 2});
        vecs.push_back('{16'h4444, 16'h4444, 2'b10, 4'd6, 8});
        vecs.push_back('{16'hF000, 16'hF000, 2'b10, 4'd3, 5});
        vecs.push_back('{16'hFFFF, 16'hF000, 2'b01, 4'd0, 2});
        vecs.push_back('{16'h2222, 16'h0000, 2'b01, 4'd5, 7});
        vecs.push_back('{16'hFFFF, 16'h3C3C, 2'b11, 4'd0, FULL_LAT});
        vecs.push_back('{16'h0007, 16'h0000, 2'b00, 4'd0, FULL_LAT});
        if (DIAG) begin
            vecs.push_back('{16'h8421, 16'h0000, 2'b01, 4'd8, 10});
            vecs.push_back('{16'h1248, 16'h1248, 2'b10, 4'd9, 11});
        end else begin
            vecs.push_back('{16'h8421, 16'h0000, 2'b00, 4'd0, 9});
            vecs.push_back('{16'h1248, 16'h1248, 2'b00, 4'd0, 9});
        end

        reset = 1'b1;
        bus.start = 1'b0;
        bus.in_gameboard = '0;
        bus.in_players_cells = '0;
        do_reset();
        check("rst_status", {30'd0, bus.out_game_status}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_win_line", {28'd0, bus.win_line}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            launch(vecs[i].board, vecs[i].cells, vecs[i].status, vecs[i].line, vecs[i].lat, s);
            wait_drain("vector");
            @(negedge clk);
            check("busy_after_done", {31'd0, bus.busy}, 32'd0);
        end

        // Draw is terminal: a later start is ignored.
        do_reset();
        launch(16'hFFFF, 16'h3C3C, 2'b11, 4'd0, FULL_LAT, s);
        wait_drain("draw");
        dc = done_count;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_gameboard = 16'h000F;
        bus.in_players_cells = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        check("draw_start_busy", {31'd0, bus.busy}, 32'd0);
        repeat (15) @(negedge clk);
        check("draw_no_done", done_count, dc);
        check("draw_status_hold", {30'd0, bus.out_game_status}, 32'd3);

        // A win is terminal too: status and line hold through another start.
        do_reset();
        launch(16'h000F, 16'h0000, 2'b01, 4'd0, 2, s);
        wait_drain("win");
        dc = done_count;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_gameboard = 16'h4444;
        bus.in_players_cells = 16'h4444;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check("win_no_done", done_count, dc);
        check("win_status_hold", {30'd0, bus.out_game_status}, 32'd1);
        check("win_line_hold", {28'd0, bus.win_line}, 32'd0);

        // Partial board: inputs change mid-scan and start re-pulses at N+3.
        do_reset();
        dc = done_count;
        launch(16'h0007, 16'h0000, 2'b00, 4'd0, FULL_LAT, s);
        bus.in_gameboard = 16'h000F;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain("partial");
        repeat (15) @(negedge clk);
        check("partial_one_done", done_count, dc + 1);
        check("partial_status", {30'd0, bus.out_game_status}, 32'd0);

        // Reset at N+5 aborts the scan with no done pulse.
        do_reset();
        dc = done_count;
        launch(16'h0007, 16'h0000, 2'b00, 4'd0, FULL_LAT, s);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_status", {30'd0, bus.out_game_status}, 32'd0);
        check("abort_win_line", {28'd0, bus.win_line}, 32'd0);
        repeat (15) @(negedge clk);
        check("abort_no_done", done_count, dc);

        // Fresh scan after the abort starts from line 0 again.
        launch(16'h000F, 16'h0000, 2'b01, 4'd0, 2, s);
        wait_drain("after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/win_detector.md
# win_detector

Scans the 4x4 board produced by the column-selection stage for four-in-a-row and reports the game result. It snapshots the occupancy (`in_gameboard`) and ownership (`in_players_cells`) maps on a start strobe and evaluates one candidate line per clock. It then drives `out_game_status`, which feeds the `in_game_status` input of the turn FSM.

## Interface
Parameters:
- `NUM_LINES`, default 10 (8 without diagonals, see Configuration): number of candidate lines scanned; derived, not user-overridden.

Ports:
- `clk`  input  1  circuit clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  one-cycle strobe: a piece was placed, board inputs are valid this cycle
- `in_gameboard`  input  16  occupancy, bit = row*4+col, row 0 = bottom; 1 = occupied
- `in_players_cells`  input  16  ownership per cell, same indexing; 0 = Player1, 1 = Player2
- `out_game_status`  output  2  00 in progress, 01 Player1 wins, 10 Player2 wins, 11 draw
- `busy`  output  1  high while scanning
- `done`  output  1  one-cycle pulse when `out_game_status` has been updated for the current scan
- `win_line`  output  4  index of the winning line, valid when status is 01/10; else 0

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `start`=1 and status non-terminal (00) → capture both 16-bit maps into snapshot registers, line counter ← 0, go SCAN. `start` ignored when status is terminal (01/10/11).
- SCAN: evaluate line `idx`:
  - lines 0-3 = rows 0-3, lines 4-7 = columns 0-3, 8 = diagonal cells 0,5,10,15, 9 = anti-diagonal cells 3,6,9,12.
  - A line wins if all four occupancy bits are 1 and all four ownership bits are equal.
  - Win → status ← 01 (owner 0) or 10 (owner 1), `win_line` ← idx, go DONE.
  - No win and idx = NUM_LINES-1 → status ← 11 if snapshot occupancy is 16'hFFFF, else 00; go DONE.
  - Otherwise idx ← idx+1.
- DONE: `done`=1 for exactly this cycle, then IDLE unconditionally.
- Lines scanned in ascending order; the first winning line wins. The Player1/Player2 tie on one board is impossible in legal play and is resolved by scan order.
- `start` during SCAN or DONE is ignored (not queued).
- Line counter is 4 bits; never exceeds NUM_LINES-1.

## Timing
- Reset: state IDLE, `out_game_status`=00, `busy`=0, `done`=0, `win_line`=0, snapshots and counter 0. Reset mid-scan aborts immediately, with no `done`.
- `start` sampled at edge N. `busy`=1 from N+1 through the last SCAN cycle.
- Win on line k: status and `win_line` valid at N+2+k, with `done` high that same cycle.
- Full scan without win: `done` at N+NUM_LINES+1, i.e. N+11 with diagonals, N+9 without.
- `out_game_status` changes only on the cycle `done` asserts (or on reset), and holds between scans.
- Inputs need only be valid in the `start` cycle; later changes do not affect the scan.
- Terminal status persists until `reset`.

## Configuration
- `WIN_DIAG_EN` defined: NUM_LINES=10, diagonals 8 and 9 checked.
- Undefined: NUM_LINES=8, rows and columns only. The draw check still requires a full board. `win_line` never exceeds 7.

## Structure
- Shared package `connect4_pkg`:
  - status encodings ST_PLAYING, ST_P1_WIN, ST_P2_WIN, ST_DRAW
  - state enum for IDLE/SCAN/DONE
  - BOARD_W=16, ROWS=4, COLS=4
  - the line-to-cell-index constant table (4 indices per line)
- One sub-module, `line_eval`: combinational. Takes four occupancy bits and four ownership bits; outputs `win` and `owner`. The top selects cells via the package table indexed by the line counter.

## Test plan
- Reset, then `start` with `in_gameboard`=16'h000F and `in_players_cells`=16'h0000 → `done` at N+2, status 01, `win_line`=0.
- Column 2 filled by Player2 (`in_gameboard`=16'h4444, `in_players_cells`=16'h4444) → win on line 6, `done` at N+8, status 10, `win_line`=6.
- Diagonal: `in_gameboard`=16'h8421, `in_players_cells`=16'h0000:
  - with `WIN_DIAG_EN` → status 01, `win_line`=8, `done` at N+10;
  - without it → status 00, `done` at N+9.
- Full board, no line of one owner (`in_gameboard`=16'hFFFF, `in_players_cells`=16'h3C3C, rows alternate 0011/1100) → status 11 at N+11, `win_line`=0; a subsequent `start` is ignored (`busy` stays 0, no `done`).
- Partial board `in_gameboard`=16'h0007 → status 00 at full-scan latency. `start` pulsed again at N+3 is ignored, giving exactly one `done` pulse. Asserting `reset` at N+5 of a fresh scan gives no `done`, and all outputs return to reset values.
